// File: rtl/clk_lock_supervisor.sv
// clk_lock_supervisor
//
// Supervises a clocking wizard (PLL/MMCM) from the free-running system clock.
// Pulses the wizard reset, waits a bounded time for lock with a limited number
// of retries, qualifies lock stability and then releases the downstream system
// reset. Counts lock-loss events seen while running.
//
// Ports:
//   i_sys_clk    free-running 100 MHz system clock
//   i_rst        asynchronous reset, active-high
//   i_locked     wizard locked flag, asynchronous to i_sys_clk
//   i_retry      single-cycle pulse; restarts the sequence from FAIL
//   o_pll_rst    reset to the clocking wizard, active-high
//   o_rst_out    reset for logic on the generated clocks, active-high
//   o_ready      high only while running with a qualified lock
//   o_fail       high only in the terminal FAIL state
//   o_state      encoded FSM state (0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 RUN, 4 FAIL)
//   o_retry_cnt  lock timeouts in the current sequence
//   o_loss_cnt   saturating count of lock losses seen in RUN

module clk_lock_supervisor #(
    parameter int unsigned SYNC_STAGES      = 2,
    parameter int unsigned RST_PULSE_CYC    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYC = 1000,
    parameter int unsigned STABLE_CYC       = 64,
    parameter int unsigned MAX_RETRY        = 3,
    parameter int unsigned CNT_W            = 8,
    localparam int unsigned RETRY_W =
        ($clog2(MAX_RETRY + 1) > 2) ? $clog2(MAX_RETRY + 1) : 2
) (
    input  logic               i_sys_clk,
    input  logic               i_rst,
    input  logic               i_locked,
    input  logic               i_retry,
    output logic               o_pll_rst,
    output logic               o_rst_out,
    output logic               o_ready,
    output logic               o_fail,
    output logic [2:0]         o_state,
    output logic [RETRY_W-1:0] o_retry_cnt,
    output logic [CNT_W-1:0]   o_loss_cnt
);

    // One shared timer sized for the longest interval it must measure.
    localparam int unsigned TMR_SPAN_A =
        (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
    localparam int unsigned TMR_SPAN = (TMR_SPAN_A > STABLE_CYC) ? TMR_SPAN_A : STABLE_CYC;
    localparam int unsigned TMR_W    = (TMR_SPAN > 1) ? $clog2(TMR_SPAN) : 1;

    localparam logic [TMR_W-1:0] TMR_TOP      = TMR_W'(TMR_SPAN - 1);
    localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(RST_PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(STABLE_CYC - 1);

    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);
    localparam logic [RETRY_W-1:0] RETRY_FULL = RETRY_W'(MAX_RETRY);
    localparam logic [CNT_W-1:0]   LOSS_MAX   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        StPllRst   = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRun      = 3'd3,
        StFail     = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [CNT_W-1:0]   loss_q, loss_d;
    logic               pll_rst_q, rst_out_q, ready_q, fail_q;

    // ------------------------------------------------------------------
    // Lock synchronizer; cleared by reset so a stale lock cannot leak
    // across a reset.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Reset release stage: the first edge after i_rst falls only samples
    // the deassertion; the FSM starts advancing on the following edge.
    // ------------------------------------------------------------------
    logic armed_q;

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, timer and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        if (armed_q) begin
            unique case (state_q)
                StPllRst: begin
                    // locked_s is deliberately ignored while the wizard is held in reset
                    if (timer_q == RST_LAST) begin
                        state_d = StWaitLock;
                    end
                end

                StWaitLock: begin
                    // Lock has priority over a timeout landing on the same cycle
                    if (locked_s) begin
                        state_d = StStable;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        if (retry_q == RETRY_LAST) begin
                            state_d = StFail;
                            retry_d = RETRY_FULL;
                        end else begin
                            state_d = StPllRst;
                            retry_d = retry_q + RETRY_W'(1);
                        end
                    end
                end

                StStable: begin
                    // A dropout is a glitch, not a timeout: retry count is kept
                    if (!locked_s) begin
                        state_d = StWaitLock;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d = StRun;
                        retry_d = '0;
                    end
                end

                StRun: begin
                    if (!locked_s) begin
                        state_d = StPllRst;
                        if (loss_q != LOSS_MAX) begin
                            loss_d = loss_q + CNT_W'(1);
                        end
                    end
                end

                StFail: begin
                    if (i_retry) begin
                        state_d = StPllRst;
                        retry_d = '0;
                    end
                end

                default: begin
                    state_d = StPllRst;
                end
            endcase

            // Timer restarts on every state entry and saturates otherwise
            if (state_d != state_q) begin
                timer_d = '0;
            end else if (timer_q != TMR_TOP) begin
                timer_d = timer_q + TMR_W'(1);
            end
        end
    end

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StPllRst;
            timer_q <= '0;
            retry_q <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
        end
    end

    // ------------------------------------------------------------------
    // Output registers, decoded from the next state so they switch on the
    // same edge as the state register.
    // ------------------------------------------------------------------
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            pll_rst_q <= 1'b1;
            rst_out_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            pll_rst_q <= (state_d == StPllRst);
            rst_out_q <= (state_d != StRun);
            ready_q   <= (state_d == StRun);
            fail_q    <= (state_d == StFail);
        end
    end

    assign o_pll_rst   = pll_rst_q;
    assign o_rst_out   = rst_out_q;
    assign o_ready     = ready_q;
    assign o_fail      = fail_q;
    assign o_state     = state_q;
    assign o_retry_cnt = retry_q;
    assign o_loss_cnt  = loss_q;

endmodule

// File: tb/tb_clk_lock_supervisor.sv
// Testbench for clk_lock_supervisor: table-driven directed vectors, hand-written
// loss/saturation/reset sequences and randomized lock waveforms checked against
// an elapsed-time reference model.

module tb_clk_lock_supervisor;

    localparam int unsigned SYNC_STAGES      = 2;
    localparam int unsigned RST_PULSE_CYC    = 4;
    localparam int unsigned LOCK_TIMEOUT_CYC = 20;
    localparam int unsigned STABLE_CYC       = 8;
    localparam int unsigned MAX_RETRY        = 2;
    localparam int unsigned CNT_W            = 2;
    localparam int          LOSS_SAT         = (1 << CNT_W) - 1;

    logic       i_sys_clk = 1'b0;
    logic       i_rst;
    logic       i_locked;
    logic       i_retry;
    logic       o_pll_rst;
    logic       o_rst_out;
    logic       o_ready;
    logic       o_fail;
    logic [2:0] o_state;
    logic [1:0] o_retry_cnt;
    logic [1:0] o_loss_cnt;

    clk_lock_supervisor #(
        .SYNC_STAGES     (SYNC_STAGES),
        .RST_PULSE_CYC   (RST_PULSE_CYC),
        .LOCK_TIMEOUT_CYC(LOCK_TIMEOUT_CYC),
        .STABLE_CYC      (STABLE_CYC),
        .MAX_RETRY       (MAX_RETRY),
        .CNT_W           (CNT_W)
    ) dut (
        .i_sys_clk  (i_sys_clk),
        .i_rst      (i_rst),
        .i_locked   (i_locked),
        .i_retry    (i_retry),
        .o_pll_rst  (o_pll_rst),
        .o_rst_out  (o_rst_out),
        .o_ready    (o_ready),
        .o_fail     (o_fail),
        .o_state    (o_state),
        .o_retry_cnt(o_retry_cnt),
        .o_loss_cnt (o_loss_cnt)
    );

    always #5 i_sys_clk = ~i_sys_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = -100;  // cycle number relative to the latest reset release
    int edge_no  = 0;     // absolute edge count

    // ------------------------------------------------------------------
    // Reference model: phase plus the edge at which it was entered; all
    // durations are elapsed-edge arithmetic.
    // ------------------------------------------------------------------
    int m_phase, m_entered, m_retries, m_losses;
    bit m_hold;
    bit m_hist[$];  // i_locked samples, newest first

    function automatic void m_reset();
        m_phase   = 0;
        m_entered = edge_no;
        m_retries = 0;
        m_losses  = 0;
        m_hold    = 1'b1;
        m_hist.delete();
    endfunction

    function automatic void m_edge(input bit lk, input bit rt);
        bit ls;
        int age;
        int nxt;
        ls = (m_hist.size() >= SYNC_STAGES) ? m_hist[SYNC_STAGES-1] : 1'b0;
        m_hist.push_front(lk);
        if (m_hist.size() > 8) void'(m_hist.pop_back());
        if (m_hold) begin
            m_hold    = 1'b0;
            m_entered = edge_no;
            return;
        end
        age = edge_no - m_entered;
        nxt = m_phase;
        case (m_phase)
            0: if (age == RST_PULSE_CYC) nxt = 1;
            1: begin
                if (ls) nxt = 2;
                else if (age == LOCK_TIMEOUT_CYC) begin
                    if (m_retries + 1 == MAX_RETRY) begin
                        nxt = 4;
                        m_retries = MAX_RETRY;
                    end else begin
                        nxt = 0;
                        m_retries++;
                    end
                end
            end
            2: begin
                if (!ls) nxt = 1;
                else if (age == STABLE_CYC) begin
                    nxt = 3;
                    m_retries = 0;
                end
            end
            3: if (!ls) begin
                nxt = 0;
                if (m_losses < LOSS_SAT) m_losses++;
            end
            4: if (rt) begin
                nxt = 0;
                m_retries = 0;
            end
            default: nxt = 0;
        endcase
        if (nxt != m_phase) begin
            m_phase   = nxt;
            m_entered = edge_no;
        end
    endfunction

    function automatic logic [10:0] dut_vec();
        return {o_state, o_pll_rst, o_rst_out, o_ready, o_fail, o_retry_cnt, o_loss_cnt};
    endfunction

    function automatic logic [10:0] exp_vec();
        logic [2:0] st;
        logic [1:0] rc;
        logic [1:0] lc;
        st = 3'(m_phase);
        rc = 2'(m_retries);
        lc = 2'(m_losses);
        return {st, m_phase == 0, m_phase != 3, m_phase == 3, m_phase == 4, rc, lc};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, got, exp);
    endtask

    // Advance one edge, step the model with the inputs seen at that edge, compare.
    task automatic tick();
        @(posedge i_sys_clk);
        edge_no++;
        cyc++;
        if (i_rst) m_reset();
        else m_edge(i_locked, i_retry);
        #1;
        check("model", 32'(dut_vec()), 32'(exp_vec()));
    endtask

    // Called just after a tick: asserts reset between edges, checks it acts
    // immediately, holds it over two edges and releases it between edges.
    task automatic do_reset();
        i_rst = 1'b1;
        #1;
        m_reset();
        check("async_reset", 32'(dut_vec()), 32'(exp_vec()));
        tick();
        tick();
        #3;
        i_rst = 1'b0;
        cyc   = -1;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        int         scen;
        int         at;
        logic       lk;   // applied after the comparison at cycle 'at'
        logic       rt;
        logic [2:0] st;
        logic       pll;
        logic       rso;
        logic       rdy;
        logic       fl;
        logic [1:0] rc;
        logic [1:0] lc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int scen, input int at, input logic lk, input logic rt,
                                input logic [2:0] st, input logic pll, input logic rso,
                                input logic rdy, input logic fl, input logic [1:0] rc,
                                input logic [1:0] lc);
        vec_t v;
        v = '{scen, at, lk, rt, st, pll, rso, rdy, fl, rc, lc};
        vecs.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int cur_scen;
        int guard;

        // Nominal lock: i_locked first sampled at edge 10.
        add(1,  0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        add(1,  3, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        add(1,  4, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1,  9, 1, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 11, 1, 0, 1, 0, 1, 0, 0, 0, 0);
        add(1, 12, 1, 0, 2, 0, 1, 0, 0, 0, 0);
        add(1, 19, 1, 0, 2, 0, 1, 0, 0, 0, 0);
        add(1, 20, 1, 0, 3, 0, 0, 1, 0, 0, 0);
        add(1, 24, 1, 0, 3, 0, 0, 1, 0, 0, 0);
        // Never lock, then retry from FAIL.
        add(2,  0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        add(2,  4, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        add(2, 23, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        add(2, 24, 0, 0, 0, 1, 1, 0, 0, 1, 0);
        add(2, 27, 0, 0, 0, 1, 1, 0, 0, 1, 0);
        add(2, 28, 0, 0, 1, 0, 1, 0, 0, 1, 0);
        add(2, 47, 0, 0, 1, 0, 1, 0, 0, 1, 0);
        add(2, 48, 0, 0, 4, 0, 1, 0, 1, 2, 0);
        add(2, 52, 0, 1, 4, 0, 1, 0, 1, 2, 0);
        add(2, 53, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        add(2, 57, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        // One timeout, lock, 3-cycle glitch in STABLE, relock to RUN.
        add(3,  0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        add(3, 24, 0, 0, 0, 1, 1, 0, 0, 1, 0);
        add(3, 25, 1, 0, 0, 1, 1, 0, 0, 1, 0);
        add(3, 28, 1, 0, 1, 0, 1, 0, 0, 1, 0);
        add(3, 29, 1, 0, 2, 0, 1, 0, 0, 1, 0);
        add(3, 31, 0, 0, 2, 0, 1, 0, 0, 1, 0);
        add(3, 34, 1, 0, 1, 0, 1, 0, 0, 1, 0);
        add(3, 36, 1, 0, 1, 0, 1, 0, 0, 1, 0);
        add(3, 37, 1, 0, 2, 0, 1, 0, 0, 1, 0);
        add(3, 44, 1, 0, 2, 0, 1, 0, 0, 1, 0);
        add(3, 45, 1, 0, 3, 0, 0, 1, 0, 0, 0);

        // Power-on reset held across two edges.
        i_rst    = 1'b1;
        i_locked = 1'b0;
        i_retry  = 1'b0;
        m_reset();
        tick();
        tick();
        #3;
        i_rst = 1'b0;
        cyc   = -1;
        cur_scen = 1;

        foreach (vecs[i]) begin
            if (vecs[i].scen != cur_scen) begin
                i_locked = 1'b0;
                i_retry  = 1'b0;
                do_reset();
                cur_scen = vecs[i].scen;
            end
            guard = 0;
            while (cyc < vecs[i].at && guard < 200) begin
                tick();
                guard++;
            end
            check($sformatf("vec%0d_s%0d_c%0d", i, vecs[i].scen, vecs[i].at),
                  32'(dut_vec()),
                  32'({vecs[i].st, vecs[i].pll, vecs[i].rso, vecs[i].rdy, vecs[i].fl,
                       vecs[i].rc, vecs[i].lc}));
            i_locked = vecs[i].lk;
            i_retry  = vecs[i].rt;
        end

        // Lock losses in RUN with counter saturation: 1, 2, 3, 3, 3.
        for (int n = 1; n <= 5; n++) begin
            tick();
            i_locked = 1'b0;
            tick();
            i_locked = 1'b1;
            check($sformatf("loss%0d_still_ready", n), 32'(o_ready), 32'd1);
            tick();
            check($sformatf("loss%0d_ready_e1", n), 32'(o_ready), 32'd1);
            tick();
            check($sformatf("loss%0d_ready_drop", n), 32'(o_ready), 32'd0);
            check($sformatf("loss%0d_rst_out", n), 32'(o_rst_out), 32'd1);
            check($sformatf("loss%0d_cnt", n), 32'(o_loss_cnt), 32'((n < 3) ? n : 3));
            for (int k = 0; k < 3; k++) tick();
            check($sformatf("loss%0d_pll_last", n), 32'(o_pll_rst), 32'd1);
            tick();
            check($sformatf("loss%0d_pll_end", n), 32'(o_pll_rst), 32'd0);
            guard = 0;
            while (!o_ready && guard < 40) begin
                tick();
                guard++;
            end
            check($sformatf("loss%0d_relock", n), 32'(o_ready), 32'd1);
        end

        // Reset in the middle of STABLE.
        i_locked = 1'b0;
        tick();
        i_locked = 1'b1;
        guard = 0;
        while (o_state != 3'd2 && guard < 40) begin
            tick();
            guard++;
        end
        tick();
        tick();
        check("pre_rst_state", 32'(o_state), 32'd2);
        check("pre_rst_loss", 32'(o_loss_cnt), 32'd3);
        do_reset();
        check("rst_loss_clear", 32'(o_loss_cnt), 32'd0);
        while (cyc < 3) tick();
        check("rst_restart_pll", 32'(o_pll_rst), 32'd1);
        tick();
        check("rst_restart_wait", 32'(o_state), 32'd1);
        tick();
        check("rst_restart_stable", 32'(o_state), 32'd2);

        // Randomized lock waveforms, retry pulses and occasional resets.
        for (int seg = 0; seg < 70; seg++) begin
            int len;
            i_locked = ($urandom_range(0, 2) != 0);
            len = i_locked ? $urandom_range(1, 40) : $urandom_range(1, 70);
            for (int k = 0; k < len; k++) begin
                i_retry = ($urandom_range(0, 7) == 0);
                tick();
            end
            i_retry = 1'b0;
            if ($urandom_range(0, 24) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
